branch_target_buffer: RTL

Direct-mapped branch target buffer with 2-bit saturating direction counters. It sits in the fetch stage, upstream of the hazard unit. Each cycle it combinationally predicts whether the fetch PC is a taken control-transfer and supplies the predicted target. These are the `pc_sel_BTB` / `pc_BTB` values that travel down the pipeline and that the hazard unit compares against the resolved outcome in EX. It is trained synchronously from the EX stage with the resolved outcome of every B-type, JAL and JALR.

---
 rtl/branch_target_buffer.sv | 107 ++++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
// branch_target_buffer
//   Direct-mapped branch target buffer with 2-bit saturating direction
//   counters. Lookup on the fetch PC is purely combinational; training
//   from the EX stage is applied on the rising clock edge.
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_reset        synchronous active-high reset
//   i_if_pc        fetch-stage PC to look up
//   o_pc_sel_BTB   predict taken: redirect fetch to o_pc_BTB
//   o_pc_BTB       predicted target, zero when not predicting taken
//   o_hit          valid entry with matching tag (any direction)
//   i_upd_en       resolved control instruction present in EX
//   i_upd_pc       PC of the EX-stage control instruction
//   i_upd_taken    resolved direction
//   i_upd_target   resolved target
//   i_upd_jump     EX instruction is JAL/JALR (always taken)
//   i_flush_all    invalidate every entry
module branch_target_buffer #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_if_pc,
  output logic        o_pc_sel_BTB,
  output logic [31:0] o_pc_BTB,
  output logic        o_hit,
  input  logic        i_upd_en,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_jump,
  input  logic        i_flush_all
);

  localparam int unsigned IDX  = $clog2(ENTRIES);
  localparam int unsigned TAGW = 30 - IDX;

  // Entry storage
  logic [ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]    tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  // Address split; pc[1:0] never participates
  logic [IDX-1:0]  if_idx;
  logic [TAGW-1:0] if_tag;
  logic [IDX-1:0]  upd_idx;
  logic [TAGW-1:0] upd_tag;
  logic            unused_pc_lsbs;

  assign if_idx         = i_if_pc[IDX+1:2];
  assign if_tag         = i_if_pc[31:IDX+2];
  assign upd_idx        = i_upd_pc[IDX+1:2];
  assign upd_tag        = i_upd_pc[31:IDX+2];
  assign unused_pc_lsbs = ^{i_if_pc[1:0], i_upd_pc[1:0]};

  // Lookup
  always_comb begin
    o_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    o_pc_sel_BTB = o_hit && ctr_q[if_idx][1];
    o_pc_BTB     = o_pc_sel_BTB ? target_q[if_idx] : '0;
  end

  // Next-state for the slot addressed by the update PC
  logic        upd_hit;
  logic        upd_tkn;
  logic        wr_en;
  logic [1:0]  ctr_d;
  logic [31:0] target_d;

  always_comb begin
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    // A jump reported as not-taken is treated as taken
    upd_tkn  = i_upd_taken || i_upd_jump;
    wr_en    = i_upd_en && (upd_hit || upd_tkn);
    ctr_d    = ctr_q[upd_idx];
    target_d = target_q[upd_idx];
    if (upd_hit && upd_tkn) begin
      ctr_d    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'b01;
      target_d = i_upd_target;
    end else if (upd_hit) begin
      ctr_d    = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'b01;
    end else if (upd_tkn) begin
      ctr_d    = i_upd_jump ? 2'b11 : 2'b10;
      target_d = i_upd_target;
    end
  end

  // Reset beats flush beats update; a coincident update is dropped
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q  <= '0;
      tag_q    <= '{default: '0};
      target_q <= '{default: '0};
      ctr_q    <= '{default: 2'b01};
    end else if (i_flush_all) begin
      valid_q  <= '0;
    end else if (wr_en) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= target_d;
      ctr_q[upd_idx]    <= ctr_d;
    end
  end

endmodule
